// File: rtl/dds_param_bank.sv
// dds_param_bank: double-buffered, multi-channel DDS parameter bank.
// Incoming parameter sets are validated and held in a per-channel shadow
// register, then transferred to the active outputs on commit, either
// immediately or at each channel's next phase-accumulator wrap.
// Optional feature macro: DDS_PARAM_CLAMP_EN -- when defined, out-of-range
// phase/amplitude/offset values are clamped instead of rejected.

module dds_param_bank #(
    parameter int CHANNELS  = 2,
    parameter int PHASE_W   = 12,
    parameter int AMP_W     = 11,
    parameter int OFS_W     = 12,
    parameter int PHASE_MAX = 2047,
    parameter int V_MAX     = 3300,
    parameter int DEF_PHASE = 10,
    parameter int DEF_AMP   = 1000,
    parameter int DEF_OFS   = 1000,
    parameter int DEF_SHAPE = 0
) (
    input  logic                        clk_100MHz,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [2:0]                  wr_chan,
    input  logic [7:0]                  wr_shape,
    input  logic [15:0]                 wr_phase_m,
    input  logic [15:0]                 wr_offset,
    input  logic [15:0]                 wr_amp,
    input  logic                        commit,
    input  logic                        sync_mode,
    input  logic [CHANNELS-1:0]         phase_wrap,
    output logic [CHANNELS*PHASE_W-1:0] phase_M,
    output logic [CHANNELS*AMP_W-1:0]   signal_A,
    output logic [CHANNELS*OFS_W-1:0]   offset,
    output logic [CHANNELS*2-1:0]       signal_shape,
    output logic [CHANNELS-1:0]         dirty,
    output logic [CHANNELS-1:0]         pending,
    output logic                        err_pulse,
    output logic [1:0]                  err_code
);

    // REJECT is the rejection leg of CHECK: it lets the error pulse land on
    // the same edge a successful STORE would, keeping write timing uniform.
    typedef enum logic [1:0] {IDLE, CHECK, STORE, REJECT} state_t;

    localparam logic [15:0]        PHASE_MAX_V = 16'(PHASE_MAX);
    localparam logic [15:0]        HALF_V      = 16'(V_MAX / 2);
    localparam logic [3:0]         CHAN_LIM    = 4'(CHANNELS);
    localparam logic [PHASE_W-1:0] DEF_PHASE_V = PHASE_W'(DEF_PHASE);
    localparam logic [AMP_W-1:0]   DEF_AMP_V   = AMP_W'(DEF_AMP);
    localparam logic [OFS_W-1:0]   DEF_OFS_V   = OFS_W'(DEF_OFS);
    localparam logic [1:0]         DEF_SHAPE_V = 2'(DEF_SHAPE);
`ifdef DDS_PARAM_CLAMP_EN
    localparam logic [15:0]        VMAX_V      = 16'(V_MAX);
`else
    localparam logic [16:0]        VMAX_17     = 17'(V_MAX);
`endif

    state_t state_q, state_d;

    logic [2:0]  rawChan_q;
    logic [7:0]  rawShape_q;
    logic [15:0] rawPhase_q, rawOfs_q, rawAmp_q;

    logic        chkErr;
    logic [1:0]  chkCode;
    logic [15:0] chkPhase, chkAmp, chkOfs;
    logic        unusedBits;

    logic storeEn, rejectEn;

    logic [CHANNELS-1:0][PHASE_W-1:0] shPhase_q, actPhase_q;
    logic [CHANNELS-1:0][AMP_W-1:0]   shAmp_q, actAmp_q;
    logic [CHANNELS-1:0][OFS_W-1:0]   shOfs_q, actOfs_q;
    logic [CHANNELS-1:0][1:0]         shShape_q, actShape_q;

    logic [CHANNELS-1:0] dirty_q, dirty_d, pending_q, pending_d;
    logic [CHANNELS-1:0] storeHit, applyHit;

    logic       errPulse_q;
    logic [1:0] errCode_q;

    // State register of the write-handling FSM.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: accept in IDLE, decide in CHECK, finish in one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (wr_valid) state_d = CHECK;
            CHECK:   state_d = chkErr ? REJECT : STORE;
            STORE:   state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake and the two one-cycle action strobes.
    always_comb begin
        wr_ready = (state_q == IDLE);
        storeEn  = (state_q == STORE);
        rejectEn = (state_q == REJECT);
    end

    // Capture the raw write fields on acceptance; they stay stable until IDLE.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            rawChan_q  <= '0;
            rawShape_q <= '0;
            rawPhase_q <= '0;
            rawOfs_q   <= '0;
            rawAmp_q   <= '0;
        end else if (state_q == IDLE && wr_valid) begin
            rawChan_q  <= wr_chan;
            rawShape_q <= wr_shape;
            rawPhase_q <= wr_phase_m;
            rawOfs_q   <= wr_offset;
            rawAmp_q   <= wr_amp;
        end
    end

    // Validate (or clamp) the latched write; later checks override earlier
    // ones so the channel check wins, then shape, then the range checks.
    always_comb begin
        chkErr   = 1'b0;
        chkCode  = 2'd0;
        chkPhase = rawPhase_q;
        chkAmp   = rawAmp_q;
        chkOfs   = rawOfs_q;
`ifdef DDS_PARAM_CLAMP_EN
        if (rawPhase_q == 16'd0)             chkPhase = 16'd1;
        else if (rawPhase_q > PHASE_MAX_V)   chkPhase = PHASE_MAX_V;
        if (rawAmp_q > HALF_V)               chkAmp   = HALF_V;
        if (rawOfs_q < chkAmp)               chkOfs   = chkAmp;
        else if (rawOfs_q > VMAX_V - chkAmp) chkOfs   = VMAX_V - chkAmp;
`else
        if (rawPhase_q == 16'd0 || rawPhase_q > PHASE_MAX_V) begin
            chkErr  = 1'b1;
            chkCode = 2'd2;
        end else if (rawAmp_q > HALF_V || rawOfs_q < rawAmp_q ||
                     ({1'b0, rawOfs_q} + {1'b0, rawAmp_q}) > VMAX_17) begin
            chkErr  = 1'b1;
            chkCode = 2'd3;
        end
`endif
        if (rawShape_q > 8'd2) begin
            chkErr  = 1'b1;
            chkCode = 2'd1;
        end
        if ({1'b0, rawChan_q} >= CHAN_LIM) begin
            chkErr  = 1'b1;
            chkCode = 2'd0;
        end
    end

    // High bits of the checked fields are provably zero after range checks.
    assign unusedBits = ^{chkPhase[15:PHASE_W], chkAmp[15:AMP_W], chkOfs[15:OFS_W]};

    // Per-channel flag updates; commit only sees dirty flags as registered.
    always_comb begin
        dirty_d   = dirty_q;
        pending_d = pending_q;
        storeHit  = '0;
        applyHit  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            storeHit[c] = storeEn && (rawChan_q == 3'(c));
            applyHit[c] = (commit && dirty_q[c] && !sync_mode) ||
                          (pending_q[c] && phase_wrap[c]);
            if (storeHit[c])                 dirty_d[c] = 1'b1;
            else if (commit && dirty_q[c])   dirty_d[c] = 1'b0;
            if (commit && dirty_q[c] && sync_mode)  pending_d[c] = 1'b1;
            else if (pending_q[c] && phase_wrap[c]) pending_d[c] = 1'b0;
        end
    end

    // Shadow and active register banks plus their dirty/pending flags.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shPhase_q[c]  <= DEF_PHASE_V;
                shAmp_q[c]    <= DEF_AMP_V;
                shOfs_q[c]    <= DEF_OFS_V;
                shShape_q[c]  <= DEF_SHAPE_V;
                actPhase_q[c] <= DEF_PHASE_V;
                actAmp_q[c]   <= DEF_AMP_V;
                actOfs_q[c]   <= DEF_OFS_V;
                actShape_q[c] <= DEF_SHAPE_V;
            end
            dirty_q   <= '0;
            pending_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (storeHit[c]) begin
                    shPhase_q[c] <= chkPhase[PHASE_W-1:0];
                    shAmp_q[c]   <= chkAmp[AMP_W-1:0];
                    shOfs_q[c]   <= chkOfs[OFS_W-1:0];
                    shShape_q[c] <= rawShape_q[1:0];
                end
                if (applyHit[c]) begin
                    actPhase_q[c] <= shPhase_q[c];
                    actAmp_q[c]   <= shAmp_q[c];
                    actOfs_q[c]   <= shOfs_q[c];
                    actShape_q[c] <= shShape_q[c];
                end
            end
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
        end
    end

    // Error reporting: single-cycle pulse and a sticky code of the last cause.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            errPulse_q <= 1'b0;
            errCode_q  <= 2'd0;
        end else begin
            errPulse_q <= rejectEn;
            if (rejectEn) errCode_q <= chkCode;
        end
    end

    assign phase_M      = actPhase_q;
    assign signal_A     = actAmp_q;
    assign offset       = actOfs_q;
    assign signal_shape = actShape_q;
    assign dirty        = dirty_q;
    assign pending      = pending_q;
    assign err_pulse    = errPulse_q;
    assign err_code     = errCode_q;

endmodule

// File: tb/tb_dds_param_bank.sv
// tb_dds_param_bank: self-checking bench for dds_param_bank.
// A table of directed writes, hand-written multi-cycle sequences, and a
// randomized phase are all compared against an event-level reference model.

module tb_dds_param_bank;

    localparam int CH   = 2;
    localparam int PW   = 12;
    localparam int AW   = 11;
    localparam int OW   = 12;
    localparam int PMAX = 2047;
    localparam int VMAX = 3300;
`ifdef DDS_PARAM_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic                clk_100MHz = 1'b0;
    logic                rst_n;
    logic                wr_valid;
    logic                wr_ready;
    logic [2:0]          wr_chan;
    logic [7:0]          wr_shape;
    logic [15:0]         wr_phase_m;
    logic [15:0]         wr_offset;
    logic [15:0]         wr_amp;
    logic                commit;
    logic                sync_mode;
    logic [CH-1:0]       phase_wrap;
    logic [CH*PW-1:0]    phase_M;
    logic [CH*AW-1:0]    signal_A;
    logic [CH*OW-1:0]    offset;
    logic [CH*2-1:0]     signal_shape;
    logic [CH-1:0]       dirty;
    logic [CH-1:0]       pending;
    logic                err_pulse;
    logic [1:0]          err_code;

    always #5 clk_100MHz = ~clk_100MHz;

    dds_param_bank #(
        .CHANNELS(CH), .PHASE_W(PW), .AMP_W(AW), .OFS_W(OW),
        .PHASE_MAX(PMAX), .V_MAX(VMAX), .DEF_PHASE(10), .DEF_AMP(1000),
        .DEF_OFS(1000), .DEF_SHAPE(0)
    ) dut (
        .clk_100MHz(clk_100MHz), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
        .wr_shape(wr_shape), .wr_phase_m(wr_phase_m), .wr_offset(wr_offset),
        .wr_amp(wr_amp), .commit(commit), .sync_mode(sync_mode),
        .phase_wrap(phase_wrap), .phase_M(phase_M), .signal_A(signal_A),
        .offset(offset), .signal_shape(signal_shape), .dirty(dirty),
        .pending(pending), .err_pulse(err_pulse), .err_code(err_code)
    );

    int asserts  = 0;
    int failures = 0;

    // Reference model: parameter sets per channel plus flags.
    int mActP[CH], mActA[CH], mActO[CH], mActS[CH];
    int mShP[CH],  mShA[CH],  mShO[CH],  mShS[CH];
    int mDirty[CH], mPend[CH];
    int mErrCode;

    typedef struct {
        int ch, sh, m, ofs, amp;
        int expCode;
        int expP, expA, expO, expS;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input int actual, input int expected);
        asserts++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < CH; c++) begin
            mActP[c] = 10; mActA[c] = 1000; mActO[c] = 1000; mActS[c] = 0;
            mShP[c]  = 10; mShA[c]  = 1000; mShO[c]  = 1000; mShS[c]  = 0;
            mDirty[c] = 0; mPend[c] = 0;
        end
        mErrCode = 0;
    endtask

    // Returns -1 when accepted (with the final stored values), else the code.
    function automatic int modelCheck(input int ch, input int sh, input int m,
                                      input int ofs, input int amp,
                                      output int pm, output int pa, output int po);
        pm = m; pa = amp; po = ofs;
        if (ch >= CH) return 0;
        if (sh > 2)   return 1;
        if (CLAMP) begin
            pm = (m < 1) ? 1 : ((m > PMAX) ? PMAX : m);
            pa = (amp > VMAX / 2) ? VMAX / 2 : amp;
            po = (ofs < pa) ? pa : ((ofs > VMAX - pa) ? VMAX - pa : ofs);
            return -1;
        end
        if (m == 0 || m > PMAX) return 2;
        if (amp > VMAX / 2 || ofs < amp || ofs + amp > VMAX) return 3;
        return -1;
    endfunction

    task automatic modelCommit(input bit sync);
        for (int c = 0; c < CH; c++) begin
            if (mDirty[c] != 0) begin
                if (sync) mPend[c] = 1;
                else begin
                    mActP[c] = mShP[c]; mActA[c] = mShA[c];
                    mActO[c] = mShO[c]; mActS[c] = mShS[c];
                end
                mDirty[c] = 0;
            end
        end
    endtask

    task automatic modelWrap(input logic [CH-1:0] mask);
        for (int c = 0; c < CH; c++) begin
            if (mask[c] && mPend[c] != 0) begin
                mActP[c] = mShP[c]; mActA[c] = mShA[c];
                mActO[c] = mShO[c]; mActS[c] = mShS[c];
                mPend[c] = 0;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("%s phase_M[%0d]", tag, c), int'(phase_M[c*PW +: PW]), mActP[c]);
            checkOutput($sformatf("%s signal_A[%0d]", tag, c), int'(signal_A[c*AW +: AW]), mActA[c]);
            checkOutput($sformatf("%s offset[%0d]", tag, c), int'(offset[c*OW +: OW]), mActO[c]);
            checkOutput($sformatf("%s shape[%0d]", tag, c), int'(signal_shape[c*2 +: 2]), mActS[c]);
            checkOutput($sformatf("%s dirty[%0d]", tag, c), int'(dirty[c]), mDirty[c]);
            checkOutput($sformatf("%s pending[%0d]", tag, c), int'(pending[c]), mPend[c]);
        end
    endtask

    // Drive one write; optionally pulse commit (immediate) on its STORE edge.
    task automatic applyStimulus(input int ch, input int sh, input int m, input int ofs,
                                 input int amp, input bit commitAtStore);
        int code, pp, pa, po, n;
        code = modelCheck(ch, sh, m, ofs, amp, pp, pa, po);
        wr_valid = 1'b1; wr_chan = 3'(ch); wr_shape = 8'(sh);
        wr_phase_m = 16'(m); wr_offset = 16'(ofs); wr_amp = 16'(amp);
        n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            @(negedge clk_100MHz);
            n++;
        end
        if (n >= 20) begin
            checkOutput("accept timeout", 0, 1);
            wr_valid = 1'b0;
            return;
        end
        @(negedge clk_100MHz);
        wr_valid = 1'b0;
        checkOutput("wr_ready in check", int'(wr_ready), 0);
        @(negedge clk_100MHz);
        checkOutput("err_pulse early", int'(err_pulse), 0);
        for (int c = 0; c < CH; c++)
            checkOutput($sformatf("dirty[%0d] early", c), int'(dirty[c]), mDirty[c]);
        if (commitAtStore) begin
            commit = 1'b1; sync_mode = 1'b0;
        end
        @(negedge clk_100MHz);
        commit = 1'b0;
        if (commitAtStore) modelCommit(1'b0);
        if (code < 0) begin
            mShP[ch] = pp; mShA[ch] = pa; mShO[ch] = po; mShS[ch] = sh;
            mDirty[ch] = 1;
        end else begin
            mErrCode = code;
        end
        checkOutput("err_pulse", int'(err_pulse), (code >= 0) ? 1 : 0);
        checkOutput("err_code", int'(err_code), mErrCode);
        checkOutput("wr_ready after", int'(wr_ready), 1);
        checkAll("write");
        @(negedge clk_100MHz);
        checkOutput("err_pulse width", int'(err_pulse), 0);
    endtask

    task automatic applyCommit(input bit sync, input logic [CH-1:0] mask);
        commit = 1'b1; sync_mode = sync; phase_wrap = mask;
        @(negedge clk_100MHz);
        commit = 1'b0; phase_wrap = '0;
        modelWrap(mask);
        modelCommit(sync);
        checkAll(sync ? "sync commit" : "commit");
    endtask

    task automatic applyWrap(input logic [CH-1:0] mask);
        phase_wrap = mask;
        @(negedge clk_100MHz);
        phase_wrap = '0;
        modelWrap(mask);
        checkAll("wrap");
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ch, sh, m, ofs, amp, op, chk;

        vecs[0]  = '{1, 1, 100,   1650, 1000, -1,              100,  1000, 1650, 1};
        vecs[1]  = '{0, 0, 0,     1000, 1000, CLAMP ? -1 : 2,  1,    1000, 1000, 0};
        vecs[2]  = '{0, 2, 50,    1000, 1200, CLAMP ? -1 : 3,  50,   1200, 1200, 2};
        vecs[3]  = '{2, 1, 100,   1650, 1000, 0,               0,    0,    0,    0};
        vecs[4]  = '{0, 3, 100,   1650, 1000, 1,               0,    0,    0,    0};
        vecs[5]  = '{0, 1, 2047,  1650, 1650, -1,              2047, 1650, 1650, 1};
        vecs[6]  = '{1, 0, 2048,  2000, 100,  CLAMP ? -1 : 2,  2047, 100,  2000, 0};
        vecs[7]  = '{1, 2, 1,     3300, 0,    -1,              1,    0,    3300, 2};
        vecs[8]  = '{0, 0, 5,     3000, 500,  CLAMP ? -1 : 3,  5,    500,  2800, 0};
        vecs[9]  = '{0, 2, 700,   1700, 1651, CLAMP ? -1 : 3,  700,  1650, 1650, 2};
        vecs[10] = '{7, 5, 0,     0,    2000, 0,               0,    0,    0,    0};
        vecs[11] = '{1, 5, 0,     0,    2000, 1,               0,    0,    0,    0};
        vecs[12] = '{0, 1, 300,   1651, 1650, CLAMP ? -1 : 3,  300,  1650, 1650, 1};
        vecs[13] = '{1, 0, 65535, 500,  400,  CLAMP ? -1 : 2,  2047, 400,  500,  0};

        rst_n = 1'b0; wr_valid = 1'b0; wr_chan = '0; wr_shape = '0;
        wr_phase_m = '0; wr_offset = '0; wr_amp = '0;
        commit = 1'b0; sync_mode = 1'b0; phase_wrap = '0;
        modelReset();
        idle(3);
        rst_n = 1'b1;
        idle(1);
        $display("[TB] reset state");
        checkAll("reset");
        checkOutput("reset wr_ready", int'(wr_ready), 1);
        checkOutput("reset err_pulse", int'(err_pulse), 0);
        checkOutput("reset err_code", int'(err_code), 0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].ch, vecs[i].sh, vecs[i].m, vecs[i].ofs, vecs[i].amp, 1'b0);
            if (vecs[i].expCode >= 0)
                checkOutput($sformatf("tbl%0d err_code", i), int'(err_code), vecs[i].expCode);
            applyCommit(1'b0, '0);
            ch = (vecs[i].ch < CH) ? vecs[i].ch : 0;
            if (vecs[i].expCode < 0) begin
                checkOutput($sformatf("tbl%0d phase", i), int'(phase_M[ch*PW +: PW]), vecs[i].expP);
                checkOutput($sformatf("tbl%0d amp", i), int'(signal_A[ch*AW +: AW]), vecs[i].expA);
                checkOutput($sformatf("tbl%0d ofs", i), int'(offset[ch*OW +: OW]), vecs[i].expO);
                checkOutput($sformatf("tbl%0d shape", i), int'(signal_shape[ch*2 +: 2]), vecs[i].expS);
            end else begin
                checkOutput($sformatf("tbl%0d held phase", i), int'(phase_M[ch*PW +: PW]), mActP[ch]);
            end
        end

        $display("[TB] empty commit");
        applyCommit(1'b0, '0);

        $display("[TB] sync commit with wraps at +2 and +10");
        applyStimulus(0, 2, 333, 2000, 800, 1'b0);
        applyCommit(1'b1, '0);
        idle(1);
        checkAll("pending hold");
        applyWrap(2'b01);
        idle(7);
        applyWrap(2'b01);

        $display("[TB] wrap coinciding with sync commit");
        applyStimulus(1, 1, 1234, 1500, 700, 1'b0);
        applyCommit(1'b1, 2'b10);
        applyWrap(2'b10);

        $display("[TB] write while pending");
        applyStimulus(0, 0, 77, 1600, 600, 1'b0);
        applyCommit(1'b1, '0);
        applyStimulus(0, 1, 88, 1700, 500, 1'b0);
        applyWrap(2'b11);
        applyCommit(1'b0, '0);

        $display("[TB] commit on STORE edge");
        applyStimulus(0, 2, 900, 2200, 300, 1'b0);
        applyStimulus(1, 0, 444, 1200, 1100, 1'b1);
        applyCommit(1'b0, '0);

        $display("[TB] randomized operations");
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, CH - 1));
                sh = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) begin
                    m   = int'($urandom_range(1, PMAX));
                    amp = int'($urandom_range(0, VMAX / 2));
                    ofs = int'($urandom_range(amp, VMAX - amp));
                end else begin
                    m   = int'($urandom_range(0, 2200));
                    amp = int'($urandom_range(0, 1800));
                    ofs = int'($urandom_range(0, 3500));
                end
                chk = int'($urandom_range(0, 5));
                applyStimulus(ch, sh, m, ofs, amp, chk == 0);
            end else if (op < 8) begin
                applyCommit(1'($urandom_range(0, 1)), CH'($urandom_range(0, 3)));
            end else begin
                applyWrap(CH'($urandom_range(0, 3)));
            end
        end

        $display("[TB] reset during a write");
        applyStimulus(0, 4, 100, 1000, 500, 1'b0);
        applyStimulus(1, 1, 555, 1800, 900, 1'b0);
        wr_valid = 1'b1; wr_chan = 3'd0; wr_shape = 8'd1;
        wr_phase_m = 16'd99; wr_offset = 16'd1500; wr_amp = 16'd400;
        @(negedge clk_100MHz);
        wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("mid reset");
        checkOutput("mid reset wr_ready", int'(wr_ready), 1);
        checkOutput("mid reset err_code", int'(err_code), 0);
        checkOutput("mid reset err_pulse", int'(err_pulse), 0);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        idle(3);
        checkAll("post reset");
        checkOutput("post reset wr_ready", int'(wr_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
